// File: rtl/fetch_sequencer.sv
// fetch_sequencer: consumer end of the pc/tick instruction-phase generator.
// Once per instruction slot it fetches the word at pc over a req/ack memory
// port, latches it into ir and emits one-hot phase strobes decoded from tick.
// Late memory (no ack by DEADLINE_TICK), misaligned pc and illegal tick
// values are detected and reported.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high
//   pc, tick     address and phase counter from the tick generator
//   mem_req      registered read request; held until ack or timeout
//   mem_addr     registered read address; stable while mem_req is high
//   mem_ack      read data valid
//   mem_rdata    read data
//   ir           latched instruction word (NOP_WORD on timeout/misalign)
//   ir_valid     ir holds the result for the current slot
//   fetch_err    current slot timed out
//   misalign     current slot pc[1:0] != 0
//   phase        one-hot registered decode of tick (0 for illegal tick)
//   seq_err      sticky: a tick >= TICKS has been seen since reset
//   fetch_count  completed fetches with valid data, wraps at 16'hFFFF
module fetch_sequencer #(
  parameter int unsigned TICKS         = 6,
  parameter int unsigned DEADLINE_TICK = 3,
  parameter logic [31:0] NOP_WORD      = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [2:0]       tick,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      ir,
  output logic             ir_valid,
  output logic             fetch_err,
  output logic             misalign,
  output logic [TICKS-1:0] phase,
  output logic             seq_err,
  output logic [15:0]      fetch_count
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [2:0]  DEADLINE = 3'(DEADLINE_TICK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic tick_legal;
  logic tick_zero;

  assign tick_legal = (32'(tick) < TICKS);
  assign tick_zero  = (tick == 3'd0);

  // Slot sequencing, memory handshake and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= 32'h0;
      ir          <= 32'h0;
      ir_valid    <= 1'b0;
      fetch_err   <= 1'b0;
      misalign    <= 1'b0;
      phase       <= '0;
      seq_err     <= 1'b0;
      fetch_count <= '0;
    end else begin
      phase <= tick_legal ? (TICKS'(1) << tick) : '0;
      if (!tick_legal) begin
        seq_err <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          // Late acks land here and are ignored; only tick 0 opens a slot.
          if (tick_zero) begin
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            misalign  <= 1'b0;
            if (pc[1:0] != 2'b00) begin
              ir       <= NOP_WORD;
              misalign <= 1'b1;
              ir_valid <= 1'b1;
              state    <= DONE;
            end else begin
              mem_addr <= pc;
              mem_req  <= 1'b1;
              state    <= REQ;
            end
          end
        end

        REQ: begin
          // Ack beats the deadline on a tie; tick 0 here means the slot
          // overran, so it is closed as a timeout.
          if (mem_ack) begin
            ir          <= mem_rdata;
            ir_valid    <= 1'b1;
            mem_req     <= 1'b0;
            fetch_count <= fetch_count + CNT_W'(1);
            state       <= DONE;
          end else if (tick == DEADLINE || tick_zero) begin
            ir        <= NOP_WORD;
            fetch_err <= 1'b1;
            ir_valid  <= 1'b1;
            mem_req   <= 1'b0;
            state     <= DONE;
          end
        end

        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: drives a pc/tick generator and a
// scripted memory, pushes expected slot results to a scoreboard and pops
// them when the DUT presents a new result.
module tb_fetch_sequencer;

  localparam int unsigned TICKS    = 6;
  localparam int unsigned DEADLINE = 3;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic             clock;
  logic             reset;
  logic [31:0]      pc;
  logic [2:0]       tick;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  logic [31:0]      ir;
  logic             ir_valid;
  logic             fetch_err;
  logic             misalign;
  logic [TICKS-1:0] phase;
  logic             seq_err;
  logic [15:0]      fetch_count;

  fetch_sequencer #(
    .TICKS(TICKS),
    .DEADLINE_TICK(DEADLINE),
    .NOP_WORD(NOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pc(pc),
    .tick(tick),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .ir(ir),
    .ir_valid(ir_valid),
    .fetch_err(fetch_err),
    .misalign(misalign),
    .phase(phase),
    .seq_err(seq_err),
    .fetch_count(fetch_count)
  );

  typedef struct packed {
    logic [31:0] ir;
    logic        err;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'h0;
  logic        prev_valid = 1'b0;
  logic        slot_edge = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Note which edges were slot-start edges so a misaligned slot following a
  // completed one (ir_valid stays high) is still seen as a new result.
  always @(posedge clock) slot_edge = (tick == 3'd0) && !reset;

  always @(negedge clock) begin
    exp_t e;
    if (!reset && ir_valid && (!prev_valid || slot_edge)) begin
      check("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_ir", ir, e.ir);
        check("sb_fetch_err", 32'(fetch_err), 32'(e.err));
        check("sb_misalign", 32'(misalign), 32'(e.mis));
        check("sb_fetch_count", 32'(fetch_count), 32'(e.cnt));
      end
    end
    prev_valid = ir_valid;
  end

  // One full instruction slot. ack_t: tick on which the memory acks (-1 none);
  // late_t: tick on which a stray ack with junk data is driven (-1 none).
  task automatic run_slot(input logic [31:0] p, input int ack_t, input int late_t,
                          input logic [31:0] rd);
    logic aligned;
    logic accepted;
    int   end_t;
    exp_t e;
    aligned  = (p[1:0] == 2'b00);
    accepted = aligned && (ack_t >= 1) && (ack_t <= int'(DEADLINE));
    end_t    = accepted ? ack_t : int'(DEADLINE);
    if (accepted) exp_count = exp_count + 16'd1;
    e.ir  = accepted ? rd : NOP;
    e.err = aligned && !accepted;
    e.mis = !aligned;
    e.cnt = exp_count;
    sb.push_back(e);
    for (int t = 0; t < int'(TICKS); t++) begin
      tick      = 3'(t);
      pc        = p;
      mem_ack   = (t == ack_t) || (t == late_t);
      mem_rdata = (t == late_t) ? 32'hFFFF_FFFF : rd;
      step();
      check("phase", 32'(phase), 32'(1) << t);
      check("mem_req", 32'(mem_req), 32'(aligned && (t < end_t)));
      if (t == 0 && aligned) check("mem_addr", mem_addr, p);
    end
    mem_ack = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_fetch_count", 32'(fetch_count), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    pc        = 32'h0;
    tick      = 3'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    step();
    step();
    check_reset_state();

    // Normal fetches, ack one cycle after the request.
    reset = 1'b0;
    run_slot(32'h0000_0000, 1, -1, 32'hDEAD_BEEF);
    check("slot0_ir", ir, 32'hDEAD_BEEF);
    run_slot(32'h0000_0004, 1, -1, 32'hCAFE_0004);
    check("two_slots_count", 32'(fetch_count), 32'd2);

    // Memory never acks; a stray ack at tick 4 must be ignored.
    run_slot(32'h0000_0008, -1, 4, 32'h1111_1111);
    check("timeout_ir", ir, NOP);
    check("timeout_count", 32'(fetch_count), 32'd2);

    // Ack exactly on the deadline edge wins.
    run_slot(32'h0000_000C, 3, -1, 32'h1234_5678);
    check("deadline_ack_err", 32'(fetch_err), 32'd0);

    // Misaligned pc, then an aligned slot clears misalign.
    run_slot(32'h0000_0006, -1, -1, 32'h0);
    check("misalign_flag", 32'(misalign), 32'd1);
    run_slot(32'h0000_0010, 2, -1, 32'hA5A5_0010);
    check("misalign_cleared", 32'(misalign), 32'd0);

    // Illegal tick for one cycle.
    tick = 3'd7;
    step();
    check("illegal_phase", 32'(phase), 32'd0);
    check("seq_err_set", 32'(seq_err), 32'd1);
    run_slot(32'h0000_0014, 1, -1, 32'h0BAD_F00D);
    check("seq_err_sticky", 32'(seq_err), 32'd1);

    // Reset while a request is outstanding, then an ack after release.
    tick = 3'd0;
    pc   = 32'h0000_0018;
    step();
    check("midfetch_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick  = 3'd1;
    step();
    exp_count = 16'h0;
    check_reset_state();
    reset     = 1'b0;
    tick      = 3'd2;
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    step();
    mem_ack = 1'b0;
    check("post_rst_ack_ir", ir, 32'd0);
    check("post_rst_ack_count", 32'(fetch_count), 32'd0);
    check("post_rst_ack_valid", 32'(ir_valid), 32'd0);
    for (int t = 3; t < int'(TICKS); t++) begin
      tick = 3'(t);
      step();
    end
    run_slot(32'h0000_001C, 1, -1, 32'h5555_AAAA);

    @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
